uart_tx_frame: RTL and testbench
================================

Name:
uart_tx_frame

Overview:
Parametrised UART transmit framer. It replaces the fixed 8-bit, one-tick-per-bit shift register with a generic serialiser that has configurable data width, stop-bit count and on-chip bit timing. It accepts a word over a valid/ready handshake and drives the tx line LSB-first: start bit (0), data, optional parity, stop bit(s) (1). It sits between the key/command source and the board UART pin.

Parameters:
DATA_W, 8, number of data bits per frame (5..16).
STOP_BITS, 1, number of stop bits (1 or 2).
CLKS_PER_BIT, 16, clk cycles per bit period (>=2).
PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Used only when UART_TX_PARITY_EN is defined.

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts in_data this cycle
in_data  input  DATA_W  word to transmit
tx  output  1  serial line, idles high
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (synchronous, active-high) values: tx=1, busy=0, state=IDLE, bit counter and cycle counter cleared. in_ready=1 on the first cycle after reset is released.
- Reset asserted mid-frame aborts the frame. tx returns high on the next edge, and the partial frame is never completed.
- Handshake:
  - A transfer happens on a cycle where in_valid && in_ready. in_data is latched into an internal shift register.
  - in_data and in_valid are ignored when in_ready=0.
- in_ready is high:
  - in IDLE, and
  - on the final clk cycle of the last stop bit. This allows back-to-back frames with no idle gap.
- Latency: tx goes low on the clk edge after acceptance.
- Every bit holds tx stable for exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA shifts LSB-first. After DATA_W bits it goes to PARITY (macro defined) or to STOP.
  - PARITY -> STOP after one bit period.
  - STOP lasts STOP_BITS bit periods. It then goes to IDLE, or to START if a new word is accepted on the final cycle.
- Frame length in clk cycles: (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT, where P = 1 with parity, else 0.
- busy=1 from the cycle after acceptance until the cycle after the last stop bit ends. busy stays 1 continuously across back-to-back frames.
- Cycle counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT). The bit counter is sized for max(DATA_W, STOP_BITS).
- tx is driven from a register; there is no combinational path from in_data to tx.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - The PARITY state is inserted after the data bits.
  - Parity bit = XOR of the latched word, inverted if PARITY_ODD=1.
  - Parity is computed at acceptance and stored.
- Undefined:
  - No PARITY state and no parity register.
  - PARITY_ODD is ignored.
  - The frame goes DATA -> STOP.

Decomposition:
- Package uart_pkg holds:
  - the tx state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - constants UART_IDLE_LEVEL=1, UART_START_LEVEL=0, UART_PARITY_EVEN=0, UART_PARITY_ODD=1.
- Sub-module uart_bit_timer holds the CLKS_PER_BIT cycle counter.
  - Inputs: clk, reset, restart.
  - Output: bit_done, a one-cycle pulse on the last cycle of a bit period.
  - It is shared with a future uart_rx.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, no parity. Send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). in_ready=0 throughout, except on the final stop-bit cycle. busy falls after cycle 40.
- Same config, in_valid held high with 0x01 then 0xFF -> second start bit begins the cycle immediately after the first stop bit ends, with no idle cycle. busy stays 1.
- UART_TX_PARITY_EN defined:
  - PARITY_ODD=0, send 0xA5 -> parity bit 0 (four ones).
  - PARITY_ODD=1, send 0x07 -> parity bit 0.
  - Frame is 44 cycles.
- STOP_BITS=2, send 0x00 -> tx high for 8 cycles after the last data bit. in_ready asserts only on the 8th.
- Assert reset during data bit 3 -> tx=1, busy=0, in_ready=1 on the next cycle. A following send of 0x3C produces a clean full frame.
- in_valid pulsed while busy with a different value -> value ignored. The in-flight frame is unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the tx framer and bit timer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_PARITY_EVEN = 1'b0;
    localparam logic UART_PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_bit_timer.sv
// Bit-period cycle counter; bit_done flags the last clk of each bit period.
// Kept free of tx specifics so the receiver can reuse it.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || restart || bit_done)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_W bits LSB-first, optional parity, stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (PARITY_ODD picks odd/even).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx,
    output logic              busy
);

    localparam int             BIT_MAX   = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int             BCW       = $clog2(BIT_MAX);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 16 || STOP_BITS < 1 || STOP_BITS > 2 ||
        CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_frame: parameter out of range");
    end

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [BCW-1:0]    bit_cnt;
    logic              bit_done;
    logic              accept;

    // Ready also on the very last stop cycle so a queued word starts without a gap.
    assign in_ready = (state == IDLE) ||
                      (state == STOP && bit_done && bit_cnt == LAST_STOP);
    assign accept   = in_valid && in_ready;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .bit_done(bit_done)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (reset)
            par_q <= UART_PARITY_EVEN;
        else if (accept)
            par_q <= (^in_data) ^ PARITY_ODD[0];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= UART_IDLE_LEVEL;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= START;
                        tx      <= UART_START_LEVEL;
                        busy    <= 1'b1;
                        shreg   <= in_data;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= par_q;
`else
                            state   <= STOP;
                            tx      <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state   <= STOP;
                        tx      <= UART_IDLE_LEVEL;
                        bit_cnt <= '0;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_STOP) begin
                            if (accept) begin
                                state   <= START;
                                tx      <= UART_START_LEVEL;
                                shreg   <= in_data;
                                bit_cnt <= '0;
                            end else begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= UART_IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: one-stop/even and two-stop/odd instances, 4 clks per bit.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CPB = 4;
    localparam int L0  = (1 + 8 + P + 1) * CPB;
    localparam int L1  = (1 + 8 + P + 2) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       rdy0, tx0, busy0, rdy1, tx1, busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_W(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .reset(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .tx(tx0), .busy(busy0));

    uart_tx_frame #(.DATA_W(8), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .reset(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1), .tx(tx1), .busy(busy1));

    // Expected line level k cycles after the accepting edge; par is the hand-computed parity bit.
    function automatic logic frame_bit(input logic [7:0] d, input logic par, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (P == 1 && b == 9) return par;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (tx0 !== 1'b1)   begin errors++; $display("FAIL reset_tx0 got=%b exp=1", tx0); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
        if (rdy0 !== 1'b1)  begin errors++; $display("FAIL reset_rdy0 got=%b exp=1", rdy0); end
        if (tx1 !== 1'b1)   begin errors++; $display("FAIL reset_tx1 got=%b exp=1", tx1); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        if (rdy1 !== 1'b1)  begin errors++; $display("FAIL reset_rdy1 got=%b exp=1", rdy1); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL post_reset_rdy0 got=%b exp=1", rdy0); end
    endtask

    task automatic test_frame_basic();
        logic et;
        @(negedge clk);
        v0 = 1'b1; d0 = 8'hA5;
        @(posedge clk); #1 v0 = 1'b0;
        for (int k = 0; k <= L0; k++) begin
            @(negedge clk);
            et = frame_bit(8'hA5, 1'b0, k);
            checks += 3;
            if (tx0 !== et) begin errors++; $display("FAIL a5_tx k=%0d got=%b exp=%b", k, tx0, et); end
            if (rdy0 !== (k >= L0 - 1)) begin errors++; $display("FAIL a5_rdy k=%0d got=%b exp=%b", k, rdy0, k >= L0 - 1); end
            if (busy0 !== (k < L0)) begin errors++; $display("FAIL a5_busy k=%0d got=%b exp=%b", k, busy0, k < L0); end
        end
    endtask

    task automatic test_back_to_back();
        logic et;
        @(negedge clk);
        v0 = 1'b1; d0 = 8'h01;
        @(posedge clk); #1 d0 = 8'hFF;
        for (int k = 0; k <= 2 * L0; k++) begin
            @(negedge clk);
            et = (k < L0) ? frame_bit(8'h01, 1'b1, k) : frame_bit(8'hFF, 1'b0, k - L0);
            checks += 3;
            if (tx0 !== et) begin errors++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, tx0, et); end
            if (rdy0 !== (k == L0 - 1 || k >= 2 * L0 - 1))
                begin errors++; $display("FAIL b2b_rdy k=%0d got=%b", k, rdy0); end
            if (busy0 !== (k < 2 * L0)) begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy0, k < 2 * L0); end
            if (k == L0) v0 = 1'b0;
        end
    endtask

    task automatic test_stop2_ignore();
        logic et;
        @(negedge clk);
        v1 = 1'b1; d1 = 8'h00;
        @(posedge clk); #1 v1 = 1'b0;
        for (int k = 0; k <= L1; k++) begin
            @(negedge clk);
            et = frame_bit(8'h00, 1'b1, k);
            checks += 3;
            if (tx1 !== et) begin errors++; $display("FAIL stop2_tx k=%0d got=%b exp=%b", k, tx1, et); end
            if (rdy1 !== (k >= L1 - 1)) begin errors++; $display("FAIL stop2_rdy k=%0d got=%b exp=%b", k, rdy1, k >= L1 - 1); end
            if (busy1 !== (k < L1)) begin errors++; $display("FAIL stop2_busy k=%0d got=%b exp=%b", k, busy1, k < L1); end
            if (k == 10) begin v1 = 1'b1; d1 = 8'hFF; end
            if (k == 11) v1 = 1'b0;
        end
    endtask

    task automatic test_parity_odd();
        logic et;
        @(negedge clk);
        v1 = 1'b1; d1 = 8'h07;
        @(posedge clk); #1 v1 = 1'b0;
        for (int k = 0; k <= L1; k++) begin
            @(negedge clk);
            et = frame_bit(8'h07, 1'b0, k);
            checks++;
            if (tx1 !== et) begin errors++; $display("FAIL par07_tx k=%0d got=%b exp=%b", k, tx1, et); end
        end
    endtask

    task automatic test_reset_midframe();
        logic et;
        @(negedge clk);
        v0 = 1'b1; d0 = 8'h96;
        @(posedge clk); #1 v0 = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            et = frame_bit(8'h96, 1'b0, k);
            checks++;
            if (tx0 !== et) begin errors++; $display("FAIL mid_tx k=%0d got=%b exp=%b", k, tx0, et); end
        end
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (tx0 !== 1'b1)   begin errors++; $display("FAIL mid_reset_tx got=%b exp=1", tx0); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got=%b exp=0", busy0); end
        if (rdy0 !== 1'b1)  begin errors++; $display("FAIL mid_reset_rdy got=%b exp=1", rdy0); end
        rst = 1'b0;
        @(negedge clk);
        v0 = 1'b1; d0 = 8'h3C;
        @(posedge clk); #1 v0 = 1'b0;
        for (int k = 0; k <= L0; k++) begin
            @(negedge clk);
            et = frame_bit(8'h3C, 1'b0, k);
            checks += 2;
            if (tx0 !== et) begin errors++; $display("FAIL x3c_tx k=%0d got=%b exp=%b", k, tx0, et); end
            if (busy0 !== (k < L0)) begin errors++; $display("FAIL x3c_busy k=%0d got=%b exp=%b", k, busy0, k < L0); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_back_to_back();
        test_stop2_ignore();
        test_parity_odd();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
